// File: rtl/instruction_prefetch_if.sv
// Prefetch-unit bus: fetch control, imem port and decode-side valid/ready handshake.
// Head outputs come straight from registers; imem_data is combinational from imem_addr.
interface instruction_prefetch_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
);
    logic                     fetch_enable;
    logic                     redirect;
    logic [WIDTH-1:0]         redirect_pc;
    logic [WIDTH-1:0]         imem_addr;
    logic [WIDTH-1:0]         imem_data;
    logic [WIDTH-1:0]         instr_out;
    logic [WIDTH-1:0]         instr_pc;
    logic                     instr_valid;
    logic                     instr_ready;
    logic [$clog2(DEPTH):0]   occupancy;

    modport master (
        input  fetch_enable, redirect, redirect_pc, imem_data, instr_ready,
        output imem_addr, instr_out, instr_pc, instr_valid, occupancy
    );

    modport slave (
        output fetch_enable, redirect, redirect_pc, imem_data, instr_ready,
        input  imem_addr, instr_out, instr_pc, instr_valid, occupancy
    );
endinterface

// File: rtl/instruction_prefetch.sv
// Instruction prefetch queue: one-clock fetch latency, DEPTH-entry FIFO of {instr, pc}.
// A full queue stalls the PC unless the head pops in the same cycle; redirect flushes everything.
module instruction_prefetch #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 2,
    parameter int PCSTEP  = 1,
    parameter int RESETPC = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    instruction_prefetch_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] pc;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;

    logic [WIDTH-1:0] ins_q [DEPTH];
    logic [WIDTH-1:0] pc_q  [DEPTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= BOOT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        push      = 1'b0;
        case (state)
            BOOT:    state_nxt = bus.fetch_enable ? RUN : HOLD;
            RUN:     if (!bus.fetch_enable) state_nxt = HOLD;
            HOLD:    if (bus.fetch_enable)  state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
        pop  = (count != '0) && bus.instr_ready && !bus.redirect;
        // A pop frees the slot, so a full queue can still accept this cycle's fetch.
        push = (state == RUN) && bus.fetch_enable && !bus.redirect &&
               ((count < CW'(DEPTH)) || pop);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc     <= WIDTH'(RESETPC);
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.redirect) begin
            pc     <= bus.redirect_pc;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc     <= pc + WIDTH'(PCSTEP);
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            ins_q[wr_ptr] <= bus.imem_data;
            pc_q[wr_ptr]  <= pc;
        end
    end

    assign bus.imem_addr   = pc;
    assign bus.instr_out   = ins_q[rd_ptr];
    assign bus.instr_pc    = pc_q[rd_ptr];
    assign bus.instr_valid = (count != '0);
    assign bus.occupancy   = count;
endmodule

// File: tb/tb_instruction_prefetch.sv
// Bench for instruction_prefetch: directed scenarios plus a randomized run against a queue model.
module tb_instruction_prefetch;
    localparam int DEPTH = 2;

    logic       clock;
    logic       reset;
    logic [7:0] key;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] ins;
        logic [7:0] pc;
    } ent_t;

    ent_t       q[$];
    logic [7:0] mpc;
    bit         mboot;
    bit         mrun;

    instruction_prefetch_if #(.WIDTH(8), .DEPTH(DEPTH)) bus ();

    instruction_prefetch dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.imem_data = bus.imem_addr + key;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock; the model applies the same edge's rules from current inputs.
    task automatic step();
        bit   do_pop;
        bit   do_push;
        ent_t e;
        if (bus.redirect) begin
            q.delete();
            mpc = bus.redirect_pc;
        end else begin
            do_pop  = (q.size() != 0) && bus.instr_ready;
            do_push = !mboot && mrun && bus.fetch_enable &&
                      ((q.size() < DEPTH) || do_pop);
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                e.ins = mpc + key;
                e.pc  = mpc;
                q.push_back(e);
                mpc = mpc + 8'd1;
            end
        end
        mrun  = bus.fetch_enable;
        mboot = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset           = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        q.delete();
        mpc   = 8'h00;
        mboot = 1'b1;
        mrun  = 1'b0;
    endtask

    task automatic test_reset();
        key              = 8'h10;
        bus.fetch_enable = 1'b1;
        bus.instr_ready  = 1'b1;
        apply_reset();
        total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0h want 0", bus.instr_valid); end
        total++; if (bus.occupancy !== 2'd0) begin bad++; $display("FAIL reset_occ: got %0h want 0", bus.occupancy); end
        total++; if (bus.imem_addr !== 8'h00) begin bad++; $display("FAIL reset_addr: got %0h want 0", bus.imem_addr); end
        reset = 1'b1;
    endtask

    task automatic test_stream();
        key              = 8'h10;
        bus.fetch_enable = 1'b1;
        bus.instr_ready  = 1'b1;
        apply_reset();
        reset = 1'b1;
        step();
        total++; if (bus.occupancy !== 2'd0) begin bad++; $display("FAIL boot_no_push: got %0h want 0", bus.occupancy); end
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (bus.instr_valid !== 1'b1 || bus.instr_out !== 8'(8'h10 + i) || bus.instr_pc !== 8'(i)) begin
                bad++;
                $display("FAIL stream_%0d: got v=%0h ins=%0h pc=%0h want v=1 ins=%0h pc=%0h",
                         i, bus.instr_valid, bus.instr_out, bus.instr_pc, 8'(8'h10 + i), i);
            end
        end
    endtask

    task automatic test_full_stall();
        key              = 8'h10;
        bus.fetch_enable = 1'b1;
        bus.instr_ready  = 1'b0;
        apply_reset();
        reset = 1'b1;
        repeat (5) step();
        total++; if (bus.occupancy !== 2'd2) begin bad++; $display("FAIL full_occ: got %0h want 2", bus.occupancy); end
        total++; if (bus.imem_addr !== 8'h02) begin bad++; $display("FAIL full_addr_hold: got %0h want 2", bus.imem_addr); end
        total++; if (bus.instr_pc !== 8'h00 || bus.instr_out !== 8'h10) begin bad++; $display("FAIL full_head: got pc=%0h ins=%0h want pc=0 ins=10", bus.instr_pc, bus.instr_out); end
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        total++; if (bus.occupancy !== 2'd2 || bus.instr_pc !== 8'h01) begin bad++; $display("FAIL full_poppush: got occ=%0h pc=%0h want occ=2 pc=1", bus.occupancy, bus.instr_pc); end
        step();
        total++; if (bus.occupancy !== 2'd2 || bus.instr_pc !== 8'h01 || bus.imem_addr !== 8'h03) begin bad++; $display("FAIL full_hold2: got occ=%0h pc=%0h addr=%0h want occ=2 pc=1 addr=3", bus.occupancy, bus.instr_pc, bus.imem_addr); end
        bus.instr_ready = 1'b1;
        for (int i = 2; i < 5; i++) begin
            step();
            total++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'(i) || bus.instr_out !== 8'(8'h10 + i)) begin
                bad++;
                $display("FAIL drain_%0d: got v=%0h pc=%0h ins=%0h want v=1 pc=%0h", i, bus.instr_valid, bus.instr_pc, bus.instr_out, i);
            end
        end
    endtask

    task automatic test_redirect();
        key              = 8'h10;
        bus.fetch_enable = 1'b1;
        bus.instr_ready  = 1'b0;
        apply_reset();
        reset = 1'b1;
        repeat (3) step();
        bus.instr_ready = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 8'h40;
        step();
        bus.redirect = 1'b0;
        total++; if (bus.occupancy !== 2'd0 || bus.instr_valid !== 1'b0) begin bad++; $display("FAIL redir_flush: got occ=%0h v=%0h want 0 0", bus.occupancy, bus.instr_valid); end
        total++; if (bus.imem_addr !== 8'h40) begin bad++; $display("FAIL redir_addr: got %0h want 40", bus.imem_addr); end
        step();
        total++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h40 || bus.instr_out !== 8'h50) begin bad++; $display("FAIL redir_head: got v=%0h pc=%0h ins=%0h want 1 40 50", bus.instr_valid, bus.instr_pc, bus.instr_out); end
    endtask

    task automatic test_wrap();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 8'hFE;
        bus.instr_ready = 1'b1;
        step();
        bus.redirect = 1'b0;
        step();
        step();
        total++; if (bus.instr_pc !== 8'hFF || bus.imem_addr !== 8'h00) begin bad++; $display("FAIL wrap_ff: got pc=%0h addr=%0h want ff 00", bus.instr_pc, bus.imem_addr); end
        step();
        total++; if (bus.instr_pc !== 8'h00 || bus.instr_out !== 8'h10 || bus.instr_valid !== 1'b1) begin bad++; $display("FAIL wrap_00: got pc=%0h ins=%0h v=%0h want 00 10 1", bus.instr_pc, bus.instr_out, bus.instr_valid); end
    endtask

    task automatic test_async_reset();
        key              = 8'h10;
        bus.fetch_enable = 1'b1;
        bus.instr_ready  = 1'b0;
        apply_reset();
        reset = 1'b1;
        repeat (4) step();
        total++; if (bus.occupancy !== 2'd2) begin bad++; $display("FAIL areset_pre: got %0h want 2", bus.occupancy); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (bus.instr_valid !== 1'b0 || bus.occupancy !== 2'd0 || bus.imem_addr !== 8'h00) begin bad++; $display("FAIL areset_now: got v=%0h occ=%0h addr=%0h want 0 0 0", bus.instr_valid, bus.occupancy, bus.imem_addr); end
        apply_reset();
        reset = 1'b1;
    endtask

    task automatic test_random();
        key = 8'($urandom);
        apply_reset();
        reset = 1'b1;
        for (int c = 0; c < 400; c++) begin
            bus.fetch_enable = ($urandom_range(0, 7) != 0);
            bus.instr_ready  = $urandom_range(0, 1) == 1;
            bus.redirect     = ($urandom_range(0, 15) == 0);
            bus.redirect_pc  = ($urandom_range(0, 1) == 1) ? 8'hFD : 8'($urandom);
            total++; if (bus.imem_addr !== mpc) begin bad++; $display("FAIL rnd_addr c=%0d: got %0h want %0h", c, bus.imem_addr, mpc); end
            total++; if (int'(bus.occupancy) != q.size()) begin bad++; $display("FAIL rnd_occ c=%0d: got %0d want %0d", c, bus.occupancy, q.size()); end
            total++; if (bus.instr_valid !== (q.size() != 0)) begin bad++; $display("FAIL rnd_valid c=%0d: got %0h want %0h", c, bus.instr_valid, q.size() != 0); end
            if (q.size() != 0) begin
                total++;
                if (bus.instr_out !== q[0].ins || bus.instr_pc !== q[0].pc) begin
                    bad++;
                    $display("FAIL rnd_head c=%0d: got ins=%0h pc=%0h want ins=%0h pc=%0h", c, bus.instr_out, bus.instr_pc, q[0].ins, q[0].pc);
                end
            end
            step();
        end
        bus.redirect = 1'b0;
    endtask

    initial begin
        reset            = 1'b0;
        key              = 8'h10;
        bus.fetch_enable = 1'b0;
        bus.instr_ready  = 1'b0;
        bus.redirect     = 1'b0;
        bus.redirect_pc  = 8'h00;
        test_reset();
        test_stream();
        test_full_stall();
        test_redirect();
        test_wrap();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instruction_prefetch.md
INSTRUCTION_PREFETCH -- requirements
Module: instruction_prefetch

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning instruction and address width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 2, meaning prefetch queue entries (power of two, >=2).
REQ-003 The module SHALL have parameter PCSTEP, default 1, meaning PC increment per fetched instruction.
REQ-004 The module SHALL have parameter RESETPC, default 0, meaning first fetch address after reset.
REQ-005 Ports SHALL be (name, direction, width, meaning):
  clock  input  1  single clock; all state updates on its rising edge.
  reset  input  1  asynchronous, active-low reset.
  fetch_enable  input  1  1 = fetching allowed; 0 = hold PC, no push.
  redirect  input  1  branch/jump taken; flush and reload PC.
  redirect_pc  input  WIDTH  new fetch address when redirect=1.
  imem_addr  output  WIDTH  instruction memory address (= current PC).
  imem_data  input  WIDTH  instruction at imem_addr, combinational, same cycle.
  instr_out  output  WIDTH  instruction at queue head.
  instr_pc  output  WIDTH  address of instr_out.
  instr_valid  output  1  queue head holds a valid instruction.
  instr_ready  input  1  decode accepts head this cycle.
  occupancy  output  $clog2(DEPTH)+1  number of valid queue entries.

Function
REQ-006 Queue SHALL be a circular FIFO of DEPTH entries, each {instruction, pc}, with read pointer, write pointer and count registers.
REQ-007 FSM SHALL have states BOOT, RUN, HOLD; BOOT is entered on reset.
REQ-008 BOOT SHALL last exactly one clock after reset deassertion, performing no push, then go to RUN if fetch_enable=1, else HOLD.
REQ-009 RUN -> HOLD when fetch_enable=0; HOLD -> RUN when fetch_enable=1; redirect does not change state.
REQ-010 imem_addr SHALL equal the PC register at all times.
REQ-011 Push SHALL occur iff state=RUN, fetch_enable=1, redirect=0, and (count<DEPTH or pop this cycle).
REQ-012 On push, entry {imem_data, PC} SHALL be written at write pointer, write pointer SHALL advance mod DEPTH, PC SHALL become PC+PCSTEP modulo 2^WIDTH.
REQ-013 Pop SHALL occur iff instr_valid=1 and instr_ready=1 and redirect=0; read pointer advances mod DEPTH.
REQ-014 Simultaneous push and pop SHALL leave count unchanged, including when count=DEPTH.
REQ-015 instr_valid SHALL equal (count!=0); instr_out/instr_pc SHALL be the head entry, combinationally from registers only.
REQ-016 When count=0, instr_out and instr_pc SHALL be don't-care but instr_valid SHALL be 0; no pop occurs.
REQ-017 redirect=1 SHALL, at the next edge, clear count and both pointers, set PC to redirect_pc, and suppress push and pop that cycle, with priority over fetch_enable and instr_ready.
REQ-018 A handshake coinciding with redirect SHALL be treated by the consumer as discarded (flushed).
REQ-019 Fetch latency SHALL be one clock: an instruction pushed at edge N is presented with instr_valid=1 after edge N.
REQ-020 PC wrap from 2^WIDTH-PCSTEP SHALL wrap to 0 without error or stall.
REQ-021 occupancy SHALL equal count and never exceed DEPTH.

Reset
REQ-022 While reset=0: PC=RESETPC, count=0, pointers=0, state=BOOT, instr_valid=0, occupancy=0, imem_addr=RESETPC.
REQ-023 Reset assertion mid-operation SHALL discard all queued entries immediately, independent of clock.
REQ-024 Queue data storage SHALL need no reset; only control state is reset.

Verification
REQ-025 Reset release, fetch_enable=1, instr_ready=1, memory returns addr+0x10: cycle 1 BOOT no push; then instr_out 0x10,0x11,0x12... with instr_pc 0,1,2, one per clock.
REQ-026 instr_ready=0, fetch_enable=1: occupancy reaches 2 after two pushes, imem_addr holds at 2, no overwrite; ready=1 then yields pc 0,1,2 in order with no gap.
REQ-027 Queue full, instr_ready=1 for one cycle: simultaneous pop/push, occupancy stays 2, next head pc=1, tail pc=2.
REQ-028 redirect=1, redirect_pc=0x40 with 2 entries queued and instr_ready=1: next cycle occupancy=0, instr_valid=0, imem_addr=0x40; following cycle head pc=0x40.
REQ-029 PC=0xFF pushed: next imem_addr=0x00; instr_pc sequence 0xFF,0x00.
REQ-030 Reset asserted asynchronously between edges with occupancy=2: instr_valid=0, occupancy=0, imem_addr=RESETPC immediately, before the next clock edge.
